irq_ctrl: RTL and testbench

- Prioritising interrupt controller in front of the multicycle CPU's single interrupt input.
- Collects up to N_SRC peripheral interrupt lines (UART receive-ready, LED-write-done, timer, ...) and edge-latches them into pending bits.
- Arbitrates by fixed priority and drives the control unit's interrupt request plus a handler vector.
- Tracks the in-service source until the handler signals end-of-interrupt.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 153 +++++++++++++++
 tb/tb_irq_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state encoding, vector defaults and id width helper for irq_ctrl
package irq_pkg;

    localparam logic [1:0] IRQ_IDLE    = 2'd0;
    localparam logic [1:0] IRQ_REQ     = 2'd1;
    localparam logic [1:0] IRQ_SERVICE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IRQ_IDLE,
        ST_REQ     = IRQ_REQ,
        ST_SERVICE = IRQ_SERVICE
    } irq_state_t;

    localparam logic [31:0] IRQ_VEC_BASE   = 32'h0000_0080;
    localparam int          IRQ_VEC_STRIDE = 8;

    // A single-bit id is still needed when only two sources exist.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder producing valid and id
module irq_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - fixed-priority interrupt controller; IRQ_NEST_EN enables nested preemption
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter int          VEC_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              irq_in,
    input  logic                          cfg_we,
    input  logic [N_SRC:0]                cfg_wdata,
    input  logic                          int_ack,
    input  logic                          eoi,
    output logic                          int_sig,
    output logic [31:0]                   int_vector,
    output logic [id_width(N_SRC)-1:0]    cur_id,
    output logic [N_SRC-1:0]              pending,
    output logic                          busy
);

    localparam int IW = id_width(N_SRC);

    irq_state_t        state, state_nx;
    logic [N_SRC-1:0]  irq_prev;
    logic [N_SRC-1:0]  en;
    logic              gen;
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  pend_clr;
    logic              win_valid;
    logic [IW-1:0]     win_id;
    logic [31:0]       win_vec;
    logic              int_sig_nx;
    logic [31:0]       vec_nx;
    logic [IW-1:0]     cur_nx;

    assign eligible = gen ? (pending & en) : '0;
    assign win_vec  = VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);

    irq_prio_enc #(.N(N_SRC), .IW(IW)) u_win_enc (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

`ifdef IRQ_NEST_EN
    logic [N_SRC-1:0]  isr, isr_nx, isr_rest;
    logic              top_valid, rest_valid;
    logic [IW-1:0]     top_id, rest_id;

    irq_prio_enc #(.N(N_SRC), .IW(IW)) u_top_enc (
        .req   (isr),
        .valid (top_valid),
        .id    (top_id)
    );

    // Context that becomes current once the top in-service source retires.
    assign isr_rest = isr & ~(N_SRC'(1) << top_id);

    irq_prio_enc #(.N(N_SRC), .IW(IW)) u_rest_enc (
        .req   (isr_rest),
        .valid (rest_valid),
        .id    (rest_id)
    );
`endif

    always_comb begin
        state_nx   = state;
        int_sig_nx = int_sig;
        vec_nx     = int_vector;
        cur_nx     = cur_id;
        pend_clr   = '0;
`ifdef IRQ_NEST_EN
        isr_nx     = isr;
`endif
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    cur_nx     = win_id;
                    vec_nx     = win_vec;
                    int_sig_nx = 1'b1;
                    state_nx   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    pend_clr[cur_id] = 1'b1;
                    int_sig_nx       = 1'b0;
                    state_nx         = ST_SERVICE;
`ifdef IRQ_NEST_EN
                    isr_nx[cur_id]   = 1'b1;
`endif
                end
            end
            ST_SERVICE: begin
`ifdef IRQ_NEST_EN
                // End-of-interrupt is handled before any preemption in the same cycle.
                if (eoi) begin
                    isr_nx = isr_rest;
                    if (rest_valid) cur_nx = rest_id;
                    else            state_nx = ST_IDLE;
                end else if (win_valid && (!top_valid || win_id < top_id)) begin
                    cur_nx     = win_id;
                    vec_nx     = win_vec;
                    int_sig_nx = 1'b1;
                    state_nx   = ST_REQ;
                end
`else
                if (eoi) state_nx = ST_IDLE;
`endif
            end
            default: begin
                state_nx   = ST_IDLE;
                int_sig_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            irq_prev   <= '0;
            pending    <= '0;
            en         <= '0;
            gen        <= 1'b0;
            int_sig    <= 1'b0;
            int_vector <= VEC_BASE;
            cur_id     <= '0;
            busy       <= 1'b0;
`ifdef IRQ_NEST_EN
            isr        <= '0;
`endif
        end else begin
            state      <= state_nx;
            irq_prev   <= irq_in;
            // A fresh edge on the bit being acknowledged must not be lost.
            pending    <= (pending & ~pend_clr) | (irq_in & ~irq_prev);
            if (cfg_we) begin
                en  <= cfg_wdata[N_SRC-1:0];
                gen <= cfg_wdata[N_SRC];
            end
            int_sig    <= int_sig_nx;
            int_vector <= vec_nx;
            cur_id     <= cur_nx;
            busy       <= (state_nx != ST_IDLE);
`ifdef IRQ_NEST_EN
            isr        <= isr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl (IRQ_NEST_EN adds nesting vectors)
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in;
    logic        cfg_we;
    logic [4:0]  cfg_wdata;
    logic        int_ack;
    logic        eoi;
    logic        int_sig;
    logic [31:0] int_vector;
    logic [1:0]  cur_id;
    logic [3:0]  pending;
    logic        busy;

    int errors = 0;
    int checks = 0;

    irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_wdata  (cfg_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_sig    (int_sig),
        .int_vector (int_vector),
        .cur_id     (cur_id),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [4:0] v);
        cfg_we = 1'b1; cfg_wdata = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
    endtask

    task automatic ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic end_isr();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        check("rst_int_sig", 32'(int_sig), 32'd0);
        check("rst_vector", int_vector, 32'h80);
        check("rst_cur_id", 32'(cur_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single source, 2-clock latency, ack clears pending
        cfg(5'b11111);
        pulse_irq(4'b0100);
        check("t1_capture_pend", 32'(pending), 32'h4);
        check("t1_capture_sig", 32'(int_sig), 32'd0);
        tick();
        check("t1_sig", 32'(int_sig), 32'd1);
        check("t1_id", 32'(cur_id), 32'd2);
        check("t1_vec", int_vector, 32'h90);
        check("t1_busy", 32'(busy), 32'd1);
        end_isr();
        check("t1_eoi_in_req", 32'(int_sig), 32'd1);
        ack();
        check("t1_ack_pend", 32'(pending), 32'h0);
        check("t1_ack_sig", 32'(int_sig), 32'd0);
        check("t1_service_busy", 32'(busy), 32'd1);
        end_isr();
        check("t1_idle_busy", 32'(busy), 32'd0);
        ack();
        check("t1_ack_idle", 32'(busy), 32'd0);

        // Two simultaneous sources: priority order
        pulse_irq(4'b1010);
        tick();
        check("t2_id_a", 32'(cur_id), 32'd1);
        check("t2_vec_a", int_vector, 32'h88);
        ack();
        check("t2_pend_after_ack", 32'(pending), 32'h8);
        end_isr();
        check("t2_gap", 32'(int_sig), 32'd0);
        tick();
        check("t2_sig_b", 32'(int_sig), 32'd1);
        check("t2_id_b", 32'(cur_id), 32'd3);
        check("t2_vec_b", int_vector, 32'h98);
        ack(); end_isr();

        // Masked source stays pending until enabled
        cfg(5'b11110);
        pulse_irq(4'b0001);
        tick(); tick();
        check("t3_pend", 32'(pending), 32'h1);
        check("t3_masked", 32'(int_sig), 32'd0);
        cfg(5'b11111);
        check("t3_cfg_edge", 32'(int_sig), 32'd0);
        tick();
        check("t3_sig", 32'(int_sig), 32'd1);
        check("t3_vec", int_vector, 32'h80);
        ack(); end_isr();

        // Re-rise during the ack cycle: set wins
        pulse_irq(4'b0100);
        tick();
        check("t4_req", 32'(int_sig), 32'd1);
        int_ack = 1'b1; irq_in = 4'b0100;
        tick();
        int_ack = 1'b0; irq_in = '0;
        check("t4_set_wins", 32'(pending), 32'h4);
        check("t4_ack_sig", 32'(int_sig), 32'd0);
        end_isr();
        tick();
        check("t4_second_req", 32'(int_sig), 32'd1);
        check("t4_second_id", 32'(cur_id), 32'd2);
        ack(); end_isr();

        // Asynchronous reset mid-request
        pulse_irq(4'b0010);
        tick();
        check("t5_req", 32'(int_sig), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_sig", 32'(int_sig), 32'd0);
        check("t5_async_pend", 32'(pending), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_vec", int_vector, 32'h80);
        tick();
        rst = 1'b0;
        pulse_irq(4'b0001);
        tick(); tick();
        check("t5_en_cleared", 32'(int_sig), 32'd0);
        check("t5_pend_kept", 32'(pending), 32'h1);

`ifdef IRQ_NEST_EN
        // Nested preemption
        rst = 1'b1; tick(); rst = 1'b0;
        cfg(5'b11111);
        pulse_irq(4'b1000);
        tick();
        check("n_id3", 32'(cur_id), 32'd3);
        ack();
        pulse_irq(4'b0001);
        tick();
        check("n_preempt_sig", 32'(int_sig), 32'd1);
        check("n_preempt_id", 32'(cur_id), 32'd0);
        check("n_preempt_vec", int_vector, 32'h80);
        ack();
        end_isr();
        check("n_resume_busy", 32'(busy), 32'd1);
        check("n_resume_id", 32'(cur_id), 32'd3);
        end_isr();
        check("n_idle", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
